// File: rtl/alu_pkg.sv
// Opcode constants and decode helpers shared by the ALU and its sequencer.
// Sequencer FSM state type lives here too.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } seq_state_e;

  function automatic logic is_wide_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_INC) || (op == OP_DEC);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one command to the combinational ALU, waits the settle time,
// then captures result and carry into the accumulator and flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DATA_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  input  logic                  cmd_use_acc,
  output logic [3:0]            alu_func,
  output logic [DATA_W-1:0]     alu_ar,
  output logic [DATA_W-1:0]     alu_br,
  input  logic [2*DATA_W-1:0]   alu_data,
  input  logic                  alu_carry,
  output logic [2*DATA_W-1:0]   acc,
  output logic                  carry_flag,
  output logic                  zero_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_err
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  seq_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          func_q, func_d;
  logic [DATA_W-1:0]   ar_q, ar_d;
  logic [DATA_W-1:0]   br_q, br_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   op_a;
  logic                reject;
  logic [2*DATA_W-1:0] cap_acc;

  always_comb begin
    op_a    = cmd_use_acc ? acc_q[DATA_W-1:0] : cmd_a;
    reject  = !is_legal_op(cmd_op) ||
              ((cmd_op == OP_DIV) && (cmd_b == '0));
    // narrow ops only own the low half of the ALU bus
    cap_acc = is_wide_op(func_q) ? alu_data
            : {{DATA_W{1'b0}}, alu_data[DATA_W-1:0]};

    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    ar_d    = ar_q;
    br_d    = br_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (reject) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            func_d  = cmd_op;
            ar_d    = op_a;
            br_d    = cmd_b;
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd1) begin
          acc_d   = cap_acc;
          carry_d = has_carry(func_q) & alu_carry;
          zero_d  = (cap_acc == '0);
          func_d  = OP_NOP;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_q  <= OP_NOP;
      ar_q    <= '0;
      br_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_err    = err_q;
  assign alu_func   = func_q;
  assign alu_ar     = ar_q;
  assign alu_br     = br_q;
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Random and directed commands against a transaction-level expectation,
// with a behavioural ALU standing in for the real one.
module tb_alu_op_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_use_acc = 1'b0;
  logic [3:0]  alu_func;
  logic [15:0] alu_ar, alu_br;
  logic [31:0] alu_data;
  logic        alu_carry;
  logic [31:0] acc;
  logic        carry_flag, zero_flag;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_func(alu_func), .alu_ar(alu_ar), .alu_br(alu_br),
    .alu_data(alu_data), .alu_carry(alu_carry),
    .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: junk in the upper half and carry=1 on ops that
  // do not own them, so the sequencer's masking is exercised.
  function automatic logic [32:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] t;
    logic [31:0] hi;
    hi = 32'hA5A5_0000;
    case (op)
      4'd1:  begin s = {1'b0, a} + {1'b0, b}; return {s[16], hi | {16'h0, s[15:0]}}; end
      4'd2:  begin s = {1'b0, a} - {1'b0, b}; return {s[16], hi | {16'h0, s[15:0]}}; end
      4'd3:  return {1'b1, 32'(a) * 32'(b)};
      4'd4:  return {1'b1, (b == 0) ? 32'h0 : 32'(a / b)};
      4'd5:  return {1'b1, hi | {16'h0, a & b}};
      4'd6:  return {1'b1, hi | {16'h0, a | b}};
      4'd7:  return {1'b1, hi | {16'h0, ~a}};
      4'd8:  begin t = a << b; return {1'b1, hi | {16'h0, t}}; end
      4'd9:  begin t = a >> b; return {1'b1, hi | {16'h0, t}}; end
      4'd10: begin s = {1'b0, a} + 17'd1; return {s[16], hi | {16'h0, s[15:0]}}; end
      4'd11: begin s = {1'b0, a} - 17'd1; return {s[16], hi | {16'h0, s[15:0]}}; end
      default: return {1'b1, 32'hDEAD_BEEF};
    endcase
  endfunction

  logic [32:0] alu_r;
  always_comb begin
    alu_r     = alu_f(alu_func, alu_ar, alu_br);
    alu_data  = alu_r[31:0];
    alu_carry = alu_r[32];
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        exp_ready, exp_rv, exp_err, exp_carry, exp_zero;
  logic [3:0]  exp_func;
  logic [15:0] exp_ar, exp_br;
  logic [31:0] exp_acc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("alu_func", 32'(alu_func), 32'(exp_func));
      chk("alu_ar", 32'(alu_ar), 32'(exp_ar));
      chk("alu_br", 32'(alu_br), 32'(exp_br));
      chk("acc", acc, exp_acc);
      chk("carry_flag", 32'(carry_flag), 32'(exp_carry));
      chk("zero_flag", 32'(zero_flag), 32'(exp_zero));
    end
  end

  task automatic exp_reset();
    exp_ready = 1'b1; exp_rv = 1'b0; exp_err = 1'b0;
    exp_func = '0; exp_ar = '0; exp_br = '0;
    exp_acc = '0; exp_carry = 1'b0; exp_zero = 1'b0;
  endtask

  // Drives one command from IDLE and walks the expected timeline:
  // SETTLE cycles of issue, capture, RESP for rdelay cycles (0 = ready early).
  task automatic do_cmd(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic use_acc,
                        input int rdelay);
    logic [15:0] opa;
    logic [32:0] r;
    logic        legal;
    opa   = use_acc ? exp_acc[15:0] : a;
    legal = (op >= 4'd1) && (op <= 4'd11) && !(op == 4'd4 && b == 16'h0);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_use_acc = use_acc;
    rsp_ready = (rdelay == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = $urandom_range(0, 15); cmd_a = $urandom; cmd_b = $urandom;
    exp_ready = 1'b0;
    if (legal) begin
      exp_func = op; exp_ar = opa; exp_br = b;
      repeat (SETTLE - 1) @(posedge clk);
      @(posedge clk); #1;
      r = alu_f(op, opa, b);
      exp_acc   = (op == 4'd3 || op == 4'd4) ? r[31:0] : {16'h0, r[15:0]};
      exp_carry = (op == 4'd1 || op == 4'd2 || op == 4'd10 || op == 4'd11)
                  ? r[32] : 1'b0;
      exp_zero  = (exp_acc == 32'h0);
      exp_func  = 4'd0;
      exp_rv    = 1'b1;
    end else begin
      exp_rv  = 1'b1;
      exp_err = 1'b1;
    end
    if (rdelay > 0) begin
      cmd_valid = 1'b1;
      repeat (rdelay) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    exp_rv = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    exp_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_acc", acc, 32'h0);
    chk("reset_ready", 32'(cmd_ready), 32'h1);

    do_cmd(4'd1, 16'hFFFF, 16'h0001, 1'b0, 1);
    chk("add_acc", acc, 32'h0);
    chk("add_carry", 32'(carry_flag), 32'h1);
    chk("add_zero", 32'(zero_flag), 32'h1);

    do_cmd(4'd3, 16'h1234, 16'h0100, 1'b0, 2);
    chk("mul_acc", acc, 32'h0012_3400);
    chk("mul_carry", 32'(carry_flag), 32'h0);

    do_cmd(4'd10, 16'hBEEF, 16'h0000, 1'b1, 1);
    chk("inc_ar", 32'(alu_ar), 32'h3400);
    chk("inc_acc", acc, 32'h0000_3401);

    do_cmd(4'd4, 16'h0100, 16'h0000, 1'b0, 1);
    chk("div0_acc", acc, 32'h0000_3401);
    do_cmd(4'hE, 16'h0100, 16'h0003, 1'b0, 1);
    chk("illegal_acc", acc, 32'h0000_3401);

    do_cmd(4'd2, 16'h0005, 16'h0007, 1'b0, 5);
    chk("sub_acc", acc, 32'h0000_FFFE);
    chk("sub_borrow", 32'(carry_flag), 32'h1);

    do_cmd(4'd8, 16'h1234, 16'd16, 1'b0, 0);
    chk("shl16_acc", acc, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] rb;
      case ($urandom_range(0, 3))
        0: rb = 16'h0;
        1: rb = 16'($urandom_range(0, 20));
        default: rb = 16'($urandom);
      endcase
      do_cmd(4'($urandom_range(0, 15)), 16'($urandom), rb,
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    do_cmd(4'd6, 16'h00FF, 16'h1200, 1'b0, 1);
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_a = 16'hF0F0; cmd_b = 16'h0FF0;
    cmd_use_acc = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_ready = 1'b0; exp_func = 4'd5; exp_ar = 16'hF0F0; exp_br = 16'h0FF0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_reset();
    repeat (SETTLE + 3) @(posedge clk);
    #1;
    chk("rst_mid_acc", acc, 32'h0);
    chk("rst_mid_rv", 32'(rsp_valid), 32'h0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'h1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
